// File: rtl/prime_test.sv
// Iterative trial-division primality tester with a bit-serial restoring divider.
// Define PRIME_TEST_ODD_ONLY_EN to test only 2 and odd divisors (same results, lower latency).
module prime_test #(
  parameter int unsigned WIDTH_LOG = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic [(1<<WIDTH_LOG)-1:0]  n,
  output logic                       ready,
  output logic                       error,
  output logic                       is_prime,
  output logic [(1<<WIDTH_LOG)-1:0]  res
);

  localparam int unsigned W = 1 << WIDTH_LOG;
  localparam logic [WIDTH_LOG-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_DIV,
    S_TEST
  } state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       nr_q, nr_d;
  logic [W-1:0]       d_q, d_d;
  logic [2*W-1:0]     sq_q, sq_d;
  logic [W-1:0]       rem_q, rem_d;
  logic [W-1:0]       sh_q, sh_d;
  logic [WIDTH_LOG-1:0] cnt_q, cnt_d;
  logic               error_q, error_d;
  logic               prime_q, prime_d;
  logic [W-1:0]       res_q, res_d;
  logic [W:0]         trial;

  assign ready    = (state_q == S_IDLE);
  assign error    = error_q;
  assign is_prime = prime_q;
  assign res      = res_q;

  // The partial remainder is always < d, so W stored bits suffice; the
  // W+1-bit shifted value exists only combinationally as `trial`.
  assign trial = {rem_q, sh_q[W-1]};

  always_comb begin
    state_d = state_q;
    nr_d    = nr_q;
    d_d     = d_q;
    sq_d    = sq_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    prime_d = prime_q;
    res_d   = res_q;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          if (n < W'(2)) begin
            error_d = 1'b1;
            prime_d = 1'b0;
            res_d   = '0;
          end else begin
            nr_d    = n;
            d_d     = W'(2);
            sq_d    = (2*W)'(4);
            error_d = 1'b0;
            prime_d = 1'b0;
            res_d   = '0;
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (sq_q > {{W{1'b0}}, nr_q}) begin
          prime_d = 1'b1;
          res_d   = nr_q;
          state_d = S_IDLE;
        end else begin
          rem_d   = '0;
          sh_d    = nr_q;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (trial >= {1'b0, d_q}) begin
          rem_d = W'(trial - {1'b0, d_q});
        end else begin
          rem_d = trial[W-1:0];
        end
        sh_d  = {sh_q[W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_TEST;
        end
      end
      S_TEST: begin
        if (rem_q == '0) begin
          prime_d = 1'b0;
          res_d   = d_q;
          state_d = S_IDLE;
        end else begin
`ifdef PRIME_TEST_ODD_ONLY_EN
          if (d_q == W'(2)) begin
            d_d  = W'(3);
            sq_d = sq_q + (2*W)'({d_q, 1'b1});
          end else begin
            d_d  = d_q + W'(2);
            sq_d = sq_q + (2*W)'({d_q, 2'b00}) + (2*W)'(4);
          end
`else
          d_d  = d_q + W'(1);
          sq_d = sq_q + (2*W)'({d_q, 1'b1});
`endif
          state_d = S_CHECK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      nr_q    <= '0;
      d_q     <= '0;
      sq_q    <= '0;
      rem_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
      prime_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      nr_q    <= nr_d;
      d_q     <= d_d;
      sq_q    <= sq_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
      prime_q <= prime_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_prime_test.sv
// Self-checking bench for prime_test (W=16): directed cases plus random
// candidates checked against an arithmetic smallest-factor/latency model.
module tb_prime_test;

  localparam int unsigned WL     = 4;
  localparam int unsigned W      = 1 << WL;
  localparam int unsigned BUDGET = 10000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         go  = 1'b0;
  logic [W-1:0] n   = '0;
  logic         ready, error, is_prime;
  logic [W-1:0] res;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  prime_test #(.WIDTH_LOG(WL)) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .n        (n),
    .ready    (ready),
    .error    (error),
    .is_prime (is_prime),
    .res      (res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Smallest factor by plain trial over the divisor sequence; each divisor
  // actually divided costs W+2 edges, the final square-exceeds check costs 1.
  task automatic ref_model(input longint unsigned v, output bit err, output bit prime,
                           output longint unsigned fac, output int unsigned lat);
    longint unsigned d;
    int unsigned k;
    err = 0; prime = 0; fac = 0; lat = 0;
    if (v < 2) begin
      err = 1;
      return;
    end
    d = 2; k = 0;
    forever begin
      if (d * d > v) begin
        prime = 1; fac = v; lat = k * (W + 2) + 1;
        return;
      end
      k++;
      if (v % d == 0) begin
        fac = d; lat = k * (W + 2);
        return;
      end
`ifdef PRIME_TEST_ODD_ONLY_EN
      d = (d == 2) ? 3 : d + 2;
`else
      d = d + 1;
`endif
    end
  endtask

  task automatic issue(input int unsigned val);
    @(negedge clk);
    go = 1'b1;
    n  = W'(val);
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic finish_req(input int unsigned val, input int unsigned lat0);
    bit              e_err, e_prime;
    longint unsigned e_fac;
    int unsigned     e_lat, lat;
    ref_model(val, e_err, e_prime, e_fac, e_lat);
    lat = lat0;
    while (!ready && lat < BUDGET) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("lat n=%0d", val), lat, e_lat);
    check($sformatf("error n=%0d", val), error, e_err);
    check($sformatf("is_prime n=%0d", val), is_prime, e_prime);
    check($sformatf("res n=%0d", val), res, e_fac);
  endtask

  task automatic do_req(input int unsigned val);
    issue(val);
    if (val >= 2) check($sformatf("busy n=%0d", val), ready, 0);
    finish_req(val, 0);
  endtask

  initial begin
    int unsigned r;
    logic [W-1:0] held;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset ready", ready, 1);
    check("reset error", error, 0);
    check("reset is_prime", is_prime, 0);
    check("reset res", res, 0);

    do_req(7);
    do_req(9);
    do_req(25);
    do_req(1);
    do_req(0);
    do_req(2);
    do_req(3);
    do_req(4);
    do_req(65521);
    do_req(65535);
    do_req(65534);

    held = res;
    repeat (4) @(posedge clk);
    #1;
    check("hold res", res, held);
    check("hold ready", ready, 1);

    // Request while busy is dropped; the original n=9 result is produced.
    issue(9);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    go = 1'b1;
    n  = W'(4);
    @(posedge clk);
    #1;
    go = 1'b0;
    finish_req(9, 6);

    // Reset in the middle of a long test.
    do_req(1);
    issue(65521);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst ready", ready, 1);
    check("midrst error", error, 0);
    check("midrst is_prime", is_prime, 0);
    check("midrst res", res, 0);
    do_req(13);

    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 300);
      do_req(r);
    end
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 65535);
      do_req(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
